jelly_axi4_write_arbiter: RTL and testbench

JELLY_AXI4_WRITE_ARBITER -- requirements
Module: jelly_axi4_write_arbiter

---
 rtl/jelly_axi4_write_arbiter_pkg.sv | 34 +++
 rtl/jelly_axi4_write_arbiter_if.sv | 50 +++++
 rtl/jelly_axi4_write_arbiter_order_fifo.sv | 51 +++++
 rtl/jelly_axi4_write_arbiter.sv | 116 +++++++++++
 tb/tb_jelly_axi4_write_arbiter.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jelly_axi4_write_arbiter_pkg.sv
// Shared types for the two-port AXI4 write arbiter: AW attribute bundle,
// port index type and the default order-FIFO pointer width.
package jelly_axi4_write_arbiter_pkg;

  localparam int unsigned DEFAULT_ORDER_PTR_WIDTH = 3;

  typedef logic port_idx_t;

  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
  } aw_attr_t;

  function automatic aw_attr_t pack_attr(input logic [7:0] len, input logic [2:0] size,
                                         input logic [1:0] burst, input logic lock,
                                         input logic [3:0] cache, input logic [2:0] prot,
                                         input logic [3:0] qos);
    aw_attr_t a;
    a.len   = len;
    a.size  = size;
    a.burst = burst;
    a.lock  = lock;
    a.cache = cache;
    a.prot  = prot;
    a.qos   = qos;
    return a;
  endfunction

endpackage

// File: rtl/jelly_axi4_write_arbiter_if.sv
// AXI4 write-only channel bundle (AW, W, B). The master modport drives
// requests; the slave modport accepts them.
interface jelly_axi4_write_arbiter_if #(
  parameter int unsigned ID_WIDTH   = 6,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_SIZE  = 3
) ();
  localparam int unsigned DATA_WIDTH = 8 << DATA_SIZE;
  localparam int unsigned STRB_WIDTH = 1 << DATA_SIZE;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/jelly_axi4_write_arbiter_order_fifo.sv
// Small synchronous FIFO remembering which port owns each granted AW, so
// the W channel can be steered in AW order.
module jelly_axi4_write_arbiter_order_fifo
  import jelly_axi4_write_arbiter_pkg::*;
#(
  parameter int unsigned PTR_WIDTH = DEFAULT_ORDER_PTR_WIDTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  port_idx_t push_data,
  input  logic      pop,
  output port_idx_t pop_data,
  output logic      full,
  output logic      empty
);
  localparam int unsigned DEPTH = 1 << PTR_WIDTH;

  port_idx_t            mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_WIDTH:0]   count_q;
  logic                 do_push, do_pop;

  // A full FIFO refuses pushes even when a pop lands in the same cycle.
  assign full     = (count_q == (PTR_WIDTH + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_WIDTH + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_WIDTH + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/jelly_axi4_write_arbiter.sv
// Two-requester AXI4 write arbiter: round-robin AW into a register stage,
// W steered by an AW-order FIFO, B routed back by the extra ID MSB.
module jelly_axi4_write_arbiter
  import jelly_axi4_write_arbiter_pkg::*;
#(
  parameter int unsigned AXI_ID_WIDTH    = 6,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned AXI_DATA_SIZE   = 3,
  parameter int unsigned ORDER_PTR_WIDTH = DEFAULT_ORDER_PTR_WIDTH
) (
  input logic                       clk,
  input logic                       reset,
  jelly_axi4_write_arbiter_if.slave  s0,
  jelly_axi4_write_arbiter_if.slave  s1,
  jelly_axi4_write_arbiter_if.master m
);
  localparam int unsigned DATA_WIDTH = 8 << AXI_DATA_SIZE;
  localparam int unsigned STRB_WIDTH = 1 << AXI_DATA_SIZE;

  port_idx_t                 grant, head;
  logic                      prio_q;
  logic                      full, empty, aw_free, aw_accept, w_go, pop;
  logic [AXI_ID_WIDTH-1:0]   sel_id;
  logic [AXI_ADDR_WIDTH-1:0] sel_addr;
  aw_attr_t                  sel_attr, attr_q;
  logic [AXI_ID_WIDTH:0]     awid_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic                      awvalid_q;
  logic [DATA_WIDTH-1:0]     head_wdata;
  logic [STRB_WIDTH-1:0]     head_wstrb;

  // A lone requester wins outright; contention falls back to the priority bit.
  always_comb begin
    grant = prio_q;
    if (s0.awvalid && !s1.awvalid) grant = 1'b0;
    if (s1.awvalid && !s0.awvalid) grant = 1'b1;
  end

  assign aw_free    = !reset && (!awvalid_q || m.awready) && !full;
  assign s0.awready = aw_free && (grant == 1'b0);
  assign s1.awready = aw_free && (grant == 1'b1);
  assign aw_accept  = aw_free && (grant ? s1.awvalid : s0.awvalid);

  always_comb begin
    sel_id   = grant ? s1.awid : s0.awid;
    sel_addr = grant ? s1.awaddr : s0.awaddr;
    sel_attr = grant
             ? pack_attr(s1.awlen, s1.awsize, s1.awburst, s1.awlock, s1.awcache, s1.awprot,
                         s1.awqos)
             : pack_attr(s0.awlen, s0.awsize, s0.awburst, s0.awlock, s0.awcache, s0.awprot,
                         s0.awqos);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      awvalid_q <= 1'b0;
      awid_q    <= '0;
      awaddr_q  <= '0;
      attr_q    <= '0;
      prio_q    <= 1'b0;
    end else if (aw_accept) begin
      awvalid_q <= 1'b1;
      awid_q    <= {grant, sel_id};
      awaddr_q  <= sel_addr;
      attr_q    <= sel_attr;
      prio_q    <= ~grant;
    end else if (m.awready) begin
      awvalid_q <= 1'b0;
    end
  end

  assign m.awvalid = awvalid_q;
  assign m.awid    = awid_q;
  assign m.awaddr  = awaddr_q;
  assign m.awlen   = attr_q.len;
  assign m.awsize  = attr_q.size;
  assign m.awburst = attr_q.burst;
  assign m.awlock  = attr_q.lock;
  assign m.awcache = attr_q.cache;
  assign m.awprot  = attr_q.prot;
  assign m.awqos   = attr_q.qos;

  jelly_axi4_write_arbiter_order_fifo #(
    .PTR_WIDTH (ORDER_PTR_WIDTH)
  ) u_order_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (aw_accept),
    .push_data (grant),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // W is a pure mux on the FIFO head; nothing flows without an AW owner.
  assign w_go       = !reset && !empty;
  assign head_wdata = head ? s1.wdata : s0.wdata;
  assign head_wstrb = head ? s1.wstrb : s0.wstrb;
  assign m.wdata    = head_wdata;
  assign m.wstrb    = head_wstrb;
  assign m.wlast    = head ? s1.wlast : s0.wlast;
  assign m.wvalid   = w_go && (head ? s1.wvalid : s0.wvalid);
  assign s0.wready  = w_go && !head && m.wready;
  assign s1.wready  = w_go && head && m.wready;
  assign pop        = m.wvalid && m.wready && m.wlast;

  assign s0.bvalid = m.bvalid && !m.bid[AXI_ID_WIDTH];
  assign s1.bvalid = m.bvalid && m.bid[AXI_ID_WIDTH];
  assign s0.bid    = m.bid[AXI_ID_WIDTH-1:0];
  assign s1.bid    = m.bid[AXI_ID_WIDTH-1:0];
  assign s0.bresp  = m.bresp;
  assign s1.bresp  = m.bresp;
  assign m.bready  = !reset && (m.bid[AXI_ID_WIDTH] ? s1.bready : s0.bready);

endmodule

// File: tb/tb_jelly_axi4_write_arbiter.sv
// Directed bench for the two-port AXI4 write arbiter: arbitration order,
// AW register behaviour, W ordering, order-FIFO full handling, B routing, reset.
module tb_jelly_axi4_write_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   pushes;

  always #5 clk = ~clk;

  jelly_axi4_write_arbiter_if #(.ID_WIDTH(6)) s0_if ();
  jelly_axi4_write_arbiter_if #(.ID_WIDTH(6)) s1_if ();
  jelly_axi4_write_arbiter_if #(.ID_WIDTH(7)) m_if ();

  jelly_axi4_write_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .s0    (s0_if),
    .s1    (s1_if),
    .m     (m_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic aw0(input logic v, input logic [5:0] id, input logic [31:0] addr,
                     input logic [7:0] len);
    s0_if.awvalid = v; s0_if.awid = id; s0_if.awaddr = addr; s0_if.awlen = len;
  endtask

  task automatic aw1(input logic v, input logic [5:0] id, input logic [31:0] addr,
                     input logic [7:0] len);
    s1_if.awvalid = v; s1_if.awid = id; s1_if.awaddr = addr; s1_if.awlen = len;
  endtask

  task automatic w0(input logic v, input logic [63:0] d, input logic last);
    s0_if.wvalid = v; s0_if.wdata = d; s0_if.wlast = last; s0_if.wstrb = 8'hff;
  endtask

  task automatic w1(input logic v, input logic [63:0] d, input logic last);
    s1_if.wvalid = v; s1_if.wdata = d; s1_if.wlast = last; s1_if.wstrb = 8'hff;
  endtask

  initial begin
    aw0(1'b0, '0, '0, '0); aw1(1'b0, '0, '0, '0);
    w0(1'b0, '0, 1'b0);    w1(1'b0, '0, 1'b0);
    {s0_if.awsize, s0_if.awburst, s0_if.awlock, s0_if.awcache, s0_if.awprot, s0_if.awqos} = '0;
    {s1_if.awsize, s1_if.awburst, s1_if.awlock, s1_if.awcache, s1_if.awprot, s1_if.awqos} = '0;
    s0_if.awsize = 3'd3; s0_if.awburst = 2'd1;
    s0_if.bready = 1'b0; s1_if.bready = 1'b0;
    m_if.awready = 1'b0; m_if.wready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bid = '0; m_if.bresp = '0;

    // Reset state and gating while reset is held
    tick();
    aw0(1'b1, 6'h01, 32'h0, 8'h0);
    s0_if.bready = 1'b1;
    settle();
    chk("rst_awready0", s0_if.awready, 1'b0);
    chk("rst_bready", m_if.bready, 1'b0);
    tick();
    chk("rst_awvalid", m_if.awvalid, 1'b0);
    aw0(1'b0, 6'h0, 32'h0, 8'h0);
    s0_if.bready = 1'b0;
    reset = 1'b0;

    // s0 alone: single 4-beat burst
    tick();
    aw0(1'b1, 6'h2a, 32'h1000, 8'd3);
    settle();
    chk("s0_awready", s0_if.awready, 1'b1);
    chk("s1_awready_lose", s1_if.awready, 1'b0);
    tick();
    aw0(1'b0, 6'h0, 32'h0, 8'h0);
    settle();
    chk("m_awvalid", m_if.awvalid, 1'b1);
    chk("m_awid", m_if.awid, 7'h2a);
    chk("m_awaddr", m_if.awaddr, 32'h1000);
    chk("m_awlen", m_if.awlen, 8'd3);
    chk("m_awsize", m_if.awsize, 3'd3);
    chk("m_awburst", m_if.awburst, 2'd1);
    m_if.awready = 1'b1;
    m_if.wready = 1'b1;
    tick();
    chk("m_awvalid_drop", m_if.awvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      w0(1'b1, 64'h100 + 64'(i), i == 3);
      settle();
      chk("w_beat_valid", m_if.wvalid, 1'b1);
      chk("w_beat_data", m_if.wdata, 64'h100 + 64'(i));
      chk("w_beat_ready", s0_if.wready, 1'b1);
      tick();
    end
    w0(1'b1, 64'h999, 1'b1);
    settle();
    chk("empty_wvalid", m_if.wvalid, 1'b0);
    chk("empty_wready", s0_if.wready, 1'b0);
    w0(1'b0, '0, 1'b0);
    m_if.bvalid = 1'b1; m_if.bid = 7'h2a; m_if.bresp = 2'd2;
    s0_if.bready = 1'b1; s1_if.bready = 1'b0;
    settle();
    chk("b0_valid", s0_if.bvalid, 1'b1);
    chk("b0_other", s1_if.bvalid, 1'b0);
    chk("b0_id", s0_if.bid, 6'h2a);
    chk("b0_resp", s0_if.bresp, 2'd2);
    chk("b0_bready", m_if.bready, 1'b1);
    m_if.bvalid = 1'b0;

    // Simultaneous requests: s0 then s1, twice
    do_reset();
    aw0(1'b1, 6'h01, 32'h2000, 8'd0);
    aw1(1'b1, 6'h02, 32'h3000, 8'd0);
    settle();
    chk("rr1_s0_ready", s0_if.awready, 1'b1);
    chk("rr1_s1_wait", s1_if.awready, 1'b0);
    tick();
    aw0(1'b0, 6'h0, 32'h0, 8'h0);
    settle();
    chk("rr1_awid_s0", m_if.awid, 7'h01);
    chk("rr1_s1_ready", s1_if.awready, 1'b1);
    tick();
    aw1(1'b0, 6'h0, 32'h0, 8'h0);
    settle();
    chk("rr1_awid_s1", m_if.awid, 7'h42);
    chk("rr1_awaddr_s1", m_if.awaddr, 32'h3000);
    w0(1'b1, 64'ha0, 1'b1);
    w1(1'b1, 64'hb0, 1'b1);
    settle();
    chk("rr1_w_first", m_if.wdata, 64'ha0);
    chk("rr1_s1_wblock", s1_if.wready, 1'b0);
    tick();
    w0(1'b0, '0, 1'b0);
    settle();
    chk("rr1_w_second", m_if.wdata, 64'hb0);
    chk("rr1_s1_wready", s1_if.wready, 1'b1);
    tick();
    w1(1'b0, '0, 1'b0);
    aw0(1'b1, 6'h03, 32'h2100, 8'd0);
    aw1(1'b1, 6'h04, 32'h3100, 8'd0);
    settle();
    chk("rr2_s0_ready", s0_if.awready, 1'b1);
    chk("rr2_s1_wait", s1_if.awready, 1'b0);
    tick();
    aw0(1'b0, 6'h0, 32'h0, 8'h0);
    settle();
    chk("rr2_s1_ready", s1_if.awready, 1'b1);
    tick();
    aw1(1'b0, 6'h0, 32'h0, 8'h0);

    // Order FIFO fills to depth 8; AW register holds while stalled
    do_reset();
    m_if.awready = 1'b0;
    m_if.wready = 1'b0;
    aw0(1'b1, 6'h03, 32'h4000, 8'd0);
    settle();
    chk("fill_first_ready", s0_if.awready, 1'b1);
    tick();
    pushes = 1;
    s0_if.awaddr = 32'h4010;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("hold_awaddr", m_if.awaddr, 32'h4000);
      chk("hold_awready", s0_if.awready, 1'b0);
      tick();
    end
    m_if.awready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      settle();
      if (s0_if.awready && s0_if.awvalid) pushes++;
      tick();
      s0_if.awaddr = 32'h4000 + 32'(pushes) * 32'h10;
    end
    settle();
    chk("fill_pushes", 64'(pushes), 64'd8);
    chk("full_awready", s0_if.awready, 1'b0);
    w0(1'b1, 64'h55, 1'b1);
    m_if.wready = 1'b1;
    settle();
    chk("full_pop_awblock", s0_if.awready, 1'b0);
    chk("full_pop_wready", s0_if.wready, 1'b1);
    tick();
    w0(1'b0, '0, 1'b0);
    settle();
    chk("after_pop_awready", s0_if.awready, 1'b1);
    aw0(1'b0, 6'h0, 32'h0, 8'h0);

    // W before AW from s1 while s0 owns the head
    do_reset();
    aw0(1'b1, 6'h04, 32'h5000, 8'd1);
    tick();
    aw0(1'b0, 6'h0, 32'h0, 8'h0);
    aw1(1'b1, 6'h05, 32'h6000, 8'd0);
    w1(1'b1, 64'hc1, 1'b1);
    settle();
    chk("wb4aw_s1_wready", s1_if.wready, 1'b0);
    chk("wb4aw_s1_awready", s1_if.awready, 1'b1);
    tick();
    aw1(1'b0, 6'h0, 32'h0, 8'h0);
    settle();
    chk("wb4aw_s1_wready2", s1_if.wready, 1'b0);
    chk("wb4aw_m_wvalid", m_if.wvalid, 1'b0);
    w0(1'b1, 64'ha0, 1'b0);
    settle();
    chk("wb4aw_beat0", m_if.wdata, 64'ha0);
    chk("wb4aw_s1_block0", s1_if.wready, 1'b0);
    tick();
    w0(1'b1, 64'ha1, 1'b1);
    settle();
    chk("wb4aw_beat1", m_if.wdata, 64'ha1);
    chk("wb4aw_beat1_last", m_if.wlast, 1'b1);
    chk("wb4aw_s1_block1", s1_if.wready, 1'b0);
    tick();
    w0(1'b0, '0, 1'b0);
    settle();
    chk("wb4aw_s1_go", s1_if.wready, 1'b1);
    chk("wb4aw_s1_data", m_if.wdata, 64'hc1);
    tick();
    w1(1'b0, '0, 1'b0);
    settle();
    chk("wb4aw_drained", m_if.wvalid, 1'b0);

    // B routed by ID MSB
    m_if.bvalid = 1'b1; m_if.bid = 7'h45; m_if.bresp = 2'd1;
    s0_if.bready = 1'b0; s1_if.bready = 1'b1;
    settle();
    chk("b1_valid", s1_if.bvalid, 1'b1);
    chk("b1_id", s1_if.bid, 6'h05);
    chk("b1_resp", s1_if.bresp, 2'd1);
    chk("b1_s0_quiet", s0_if.bvalid, 1'b0);
    chk("b1_bready", m_if.bready, 1'b1);
    s1_if.bready = 1'b0;
    settle();
    chk("b1_bready_low", m_if.bready, 1'b0);

    // Reset in the middle of a burst
    m_if.awready = 1'b0;
    aw0(1'b1, 6'h06, 32'h7000, 8'd3);
    tick();
    aw0(1'b0, 6'h0, 32'h0, 8'h0);
    w0(1'b1, 64'hd0, 1'b0);
    tick();
    reset = 1'b1;
    aw0(1'b1, 6'h07, 32'h7100, 8'd0);
    s1_if.bready = 1'b1;
    settle();
    chk("mid_rst_awready", s0_if.awready, 1'b0);
    chk("mid_rst_wready", s0_if.wready, 1'b0);
    chk("mid_rst_wvalid", m_if.wvalid, 1'b0);
    chk("mid_rst_bready", m_if.bready, 1'b0);
    chk("mid_rst_bvalid", s1_if.bvalid, 1'b1);
    tick();
    reset = 1'b0;
    m_if.bvalid = 1'b0;
    aw1(1'b1, 6'h08, 32'h7200, 8'd0);
    settle();
    chk("post_rst_awvalid", m_if.awvalid, 1'b0);
    chk("post_rst_wready", s0_if.wready, 1'b0);
    chk("post_rst_wvalid", m_if.wvalid, 1'b0);
    chk("post_rst_prio_s0", s0_if.awready, 1'b1);
    chk("post_rst_prio_s1", s1_if.awready, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
